// File: rtl/alu_pkg.sv
// Shared ALU / M-extension definitions: op encoding, datapath width and
// the iterative multiply/divide state type.
package alu_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] alu_op_t;

    localparam alu_op_t OP_ADD    = 5'b00000;
    localparam alu_op_t OP_MUL    = 5'b01010;
    localparam alu_op_t OP_MULH   = 5'b01011;
    localparam alu_op_t OP_MULHU  = 5'b01100;
    localparam alu_op_t OP_MULHSU = 5'b01101;
    localparam alu_op_t OP_DIVU   = 5'b01110;
    localparam alu_op_t OP_REMU   = 5'b01111;
    localparam alu_op_t OP_DIV    = 5'b10000;
    localparam alu_op_t OP_REM    = 5'b10001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic logic is_md_op(input alu_op_t op);
        return (op >= OP_MUL) && (op <= OP_REM);
    endfunction

    function automatic logic is_mul_op(input alu_op_t op);
        return (op >= OP_MUL) && (op <= OP_MULHSU);
    endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_step
    import alu_pkg::*;
(
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            dividend_bit,
    output logic [XLEN:0]   rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The partial remainder is always below the divisor, so its top bit is
    // zero and the shifted value fits in XLEN+1 bits.
    always_comb begin
        shifted = {rem_in[XLEN-1:0], dividend_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff : shifted;
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring steps on
// operand magnitudes, with sign fix-up folded into the last step.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data
);

    md_state_t       state_q, state_d;
    alu_op_t         op_q, op_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN:0]   hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;

    logic              accept;
    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              req_is_div, div_by_zero, div_overflow;
    logic [XLEN-1:0]   special_result;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] product, product_fix;
    logic [XLEN-1:0]   mul_result;
    logic [XLEN:0]     div_rem_n;
    logic              div_q;
    logic [XLEN-1:0]   div_lo_n, quot_fix, rem_fix, div_result;

    assign req_ready  = (state_q != CALC);
    assign resp_valid = (state_q == DONE) && !kill;
    assign resp_data  = resp_data_q;

    div_step u_div_step (
        .rem_in       (hi_q),
        .divisor      (opb_q),
        .dividend_bit (lo_q[XLEN-1]),
        .rem_out      (div_rem_n),
        .q_bit        (div_q)
    );

    // Request decode: operand signedness, magnitudes and the cases that
    // bypass iteration entirely.
    always_comb begin
        accept       = req_valid && req_ready && !kill && is_md_op(req_op);
        a_signed     = (req_op == OP_MUL) || (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                       (req_op == OP_DIV) || (req_op == OP_REM);
        b_signed     = (req_op == OP_MUL) || (req_op == OP_MULH) ||
                       (req_op == OP_DIV) || (req_op == OP_REM);
        sa           = a_signed && req_a[XLEN-1];
        sb           = b_signed && req_b[XLEN-1];
        a_mag        = sa ? -req_a : req_a;
        b_mag        = sb ? -req_b : req_b;
        req_is_div   = is_md_op(req_op) && !is_mul_op(req_op);
        div_by_zero  = req_is_div && (req_b == '0);
        div_overflow = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                       (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
        if (div_by_zero) begin
            special_result = ((req_op == OP_DIV) || (req_op == OP_DIVU)) ? '1 : req_a;
        end else begin
            special_result = (req_op == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
        end
    end

    // Per-step datapath; the final-step results are signed and selected here.
    always_comb begin
        mul_sum     = {1'b0, hi_q[XLEN-1:0]} + (lo_q[0] ? {1'b0, opb_q} : '0);
        product     = {mul_sum, lo_q[XLEN-1:1]};
        product_fix = neg_q ? -product : product;
        mul_result  = (op_q == OP_MUL) ? product_fix[XLEN-1:0] : product_fix[2*XLEN-1:XLEN];
        div_lo_n    = {lo_q[XLEN-2:0], div_q};
        quot_fix    = neg_q ? -div_lo_n : div_lo_n;
        rem_fix     = rem_neg_q ? -div_rem_n[XLEN-1:0] : div_rem_n[XLEN-1:0];
        div_result  = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quot_fix : rem_fix;
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opb_d       = opb_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        neg_d       = neg_q;
        rem_neg_d   = rem_neg_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d      = req_op;
                    neg_d     = sa ^ sb;
                    rem_neg_d = sa;
                    cnt_d     = '0;
                    if (div_by_zero || div_overflow) begin
                        state_d     = DONE;
                        resp_data_d = special_result;
                    end else begin
                        state_d = CALC;
                        hi_d    = '0;
                        lo_d    = is_mul_op(req_op) ? b_mag : a_mag;
                        opb_d   = is_mul_op(req_op) ? a_mag : b_mag;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (is_mul_op(op_q)) begin
                    hi_d = {1'b0, mul_sum[XLEN:1]};
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end else begin
                    hi_d = div_rem_n;
                    lo_d = div_lo_n;
                end
                if (cnt_q == 5'd31) begin
                    state_d     = DONE;
                    resp_data_d = is_mul_op(op_q) ? mul_result : div_result;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything, including a result landing this cycle.
        if (kill) begin
            state_d     = IDLE;
            cnt_d       = '0;
            resp_data_d = resp_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            opb_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            cnt_q       <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opb_q       <= opb_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            neg_q       <= neg_d;
            rem_neg_q   <= rem_neg_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed, table-driven bench for muldiv_seq with hand-written sequences
// for back-to-back issue, kill, reset and invalid ops.
module tb_muldiv_seq;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expData;
        int          expLat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        kill;
    logic        resp_valid;
    logic [31:0] resp_data;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[16];

    muldiv_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Called at #1 after an edge; returns data, latency in cycles from the
    // request cycle and the number of cycles req_ready was low.
    task automatic issueRequest(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] data, output int lat, output int rdyLow);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = OP_ADD;
        lat       = 1;
        rdyLow    = 0;
        while (!resp_valid && lat < 100) begin
            if (!req_ready) rdyLow++;
            @(posedge clk);
            #1;
            lat++;
        end
        data = resp_data;
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] data, output int lat, output int rdyLow);
        @(posedge clk);
        #1;
        issueRequest(op, a, b, data, lat, rdyLow);
    endtask

    task automatic watchNoResponse(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
    endtask

    initial begin
        logic [31:0] data;
        int          lat;
        int          rdyLow;
        int          seen;

        vecs[0]  = '{"mul_7_x_m3",     OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{"mulh_min_sq",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{"mulhu_max_sq",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{"mulhsu_m1_max",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{"div_m7_2",       OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{"rem_m7_2",       OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{"divu_100_7",     OP_DIVU,   32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{"remu_100_7",     OP_REMU,   32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{"div_7_m2",       OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[9]  = '{"rem_7_m2",       OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[10] = '{"divu_max_1",     OP_DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33};
        vecs[11] = '{"div_5_0",        OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[12] = '{"remu_5_0",       OP_REMU,   32'd5,         32'd0,         32'd5,         1};
        vecs[13] = '{"div_ovf",        OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[14] = '{"rem_ovf",        OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[15] = '{"rem_m5_0",       OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_ADD;
        req_a     = '0;
        req_b     = '0;
        kill      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_req_ready",  32'(req_ready),  32'd1);
        checkOutput("reset_resp_data",  resp_data,       32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, data, lat, rdyLow);
            checkOutput({vecs[i].name, "_data"},     data,        vecs[i].expData);
            checkOutput({vecs[i].name, "_latency"},  32'(lat),    32'(vecs[i].expLat));
            checkOutput({vecs[i].name, "_rdy_low"},  32'(rdyLow), (vecs[i].expLat == 33) ? 32'd32 : 32'd0);
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, "_pulse_end"}, 32'(resp_valid), 32'd0);
        end

        // Back-to-back: second request presented in the DONE cycle of the first.
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, data, lat, rdyLow);
        checkOutput("b2b_first_data", data, 32'hFFFF_FFFD);
        checkOutput("b2b_ready_in_done", 32'(req_ready), 32'd1);
        issueRequest(OP_REM, 32'hFFFF_FFF9, 32'd2, data, lat, rdyLow);
        checkOutput("b2b_second_data", data, 32'hFFFF_FFFF);
        checkOutput("b2b_second_latency", 32'(lat), 32'd33);
        @(posedge clk);
        #1;

        // Kill in CALC cycle 10.
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        checkOutput("kill_calc_ready", 32'(req_ready), 32'd1);
        watchNoResponse(40, seen);
        checkOutput("kill_calc_no_resp", 32'(seen), 32'd0);
        applyStimulus(OP_DIVU, 32'd9, 32'd3, data, lat, rdyLow);
        checkOutput("after_kill_divu_data", data, 32'd3);
        checkOutput("after_kill_divu_latency", 32'(lat), 32'd33);

        // Kill in the DONE cycle of a one-cycle special case.
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = OP_DIV;
        req_a     = 32'd5;
        req_b     = 32'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        kill      = 1'b1;
        #1;
        checkOutput("kill_done_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        kill = 1'b0;
        checkOutput("kill_done_after_valid", 32'(resp_valid), 32'd0);
        checkOutput("kill_done_after_ready", 32'(req_ready), 32'd1);

        // Asynchronous reset mid-CALC.
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = OP_MUL;
        req_a     = 32'd1234;
        req_b     = 32'd5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("pre_reset_busy", 32'(req_ready), 32'd0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        checkOutput("async_reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("async_reset_ready",      32'(req_ready),  32'd1);
        checkOutput("async_reset_resp_data",  resp_data,       32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        watchNoResponse(40, seen);
        checkOutput("reset_no_late_resp", 32'(seen), 32'd0);

        // Invalid op code held valid for several cycles.
        req_valid = 1'b1;
        req_op    = OP_ADD;
        req_a     = 32'd1;
        req_b     = 32'd2;
        seen      = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid || !req_ready) seen++;
        end
        req_valid = 1'b0;
        checkOutput("invalid_op_ignored", 32'(seen), 32'd0);
        applyStimulus(OP_MUL, 32'd3, 32'd5, data, lat, rdyLow);
        checkOutput("after_invalid_mul_data", data, 32'd15);
        checkOutput("after_invalid_mul_latency", 32'(lat), 32'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
